// File: rtl/fb_bram_arbiter.sv
// rtl/fb_bram_arbiter.sv - frame-buffer BRAM arbiter, TX reads over queued capture writes
// Reads always win the port; writes wait in a 16-entry FIFO and drain on idle read slots.
module fb_bram_arbiter #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                RD_REQ,
  input  logic [ADDR_W-1:0]   RD_ADDR,
  output logic [DATA_W-1:0]   RD_DATA,
  output logic                RD_VALID,
  input  logic                WR_REQ,
  input  logic [ADDR_W-1:0]   WR_ADDR,
  input  logic [DATA_W-1:0]   WR_DATA,
  output logic                WR_READY,
  output logic [ADDR_W-1:0]   BRAM_ADDR,
  output logic [DATA_W-1:0]   BRAM_DIN,
  output logic                BRAM_WE,
  input  logic [DATA_W-1:0]   BRAM_DOUT,
  output logic [FIFO_AW:0]    FIFO_LEVEL,
  output logic                OVERFLOW
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  // Bit 1 of the encoding is the BRAM write enable, so BRAM_WE is a plain flop output.
  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_RD   = 2'b01,
    GNT_WR   = 2'b10
  } gnt_t;

  gnt_t gnt_q, gnt_d;

  logic [ADDR_W+DATA_W-1:0] fifo_mem [DEPTH];
  logic [FIFO_AW-1:0]       wr_ptr, rd_ptr;
  logic [FIFO_AW:0]         count;
  logic                     fifo_full, fifo_empty;
  logic                     push, pop;
  logic [ADDR_W-1:0]        head_addr;
  logic [DATA_W-1:0]        head_data;
  logic [1:0]               rd_sr;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign WR_READY   = ~fifo_full;
  assign FIFO_LEVEL = count;
  assign BRAM_WE    = gnt_q[1];
  assign {head_addr, head_data} = fifo_mem[rd_ptr];

  always_comb begin
    gnt_d = GNT_NONE;
    if (RD_REQ) begin
      gnt_d = GNT_RD;
    end else if (!fifo_empty) begin
      gnt_d = GNT_WR;
    end
  end

  assign push = WR_REQ & ~fifo_full;
  assign pop  = (gnt_d == GNT_WR);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      gnt_q     <= GNT_NONE;
      BRAM_ADDR <= '0;
      BRAM_DIN  <= '0;
    end else begin
      gnt_q <= gnt_d;
      case (gnt_d)
        GNT_RD: BRAM_ADDR <= RD_ADDR;
        GNT_WR: begin
          BRAM_ADDR <= head_addr;
          BRAM_DIN  <= head_data;
        end
        default: ;
      endcase
    end
  end

  // Two stages cover the address edge and the BRAM's own output register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_sr    <= '0;
      RD_VALID <= 1'b0;
      RD_DATA  <= '0;
    end else begin
      rd_sr    <= {rd_sr[0], RD_REQ};
      RD_VALID <= rd_sr[1];
      if (rd_sr[1]) begin
        RD_DATA <= BRAM_DOUT;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {WR_ADDR, WR_DATA};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (WR_REQ && fifo_full) begin
        OVERFLOW <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fb_bram_arbiter.sv
// tb/tb_fb_bram_arbiter.sv - directed and random checks of fb_bram_arbiter against a queue model
module tb_fb_bram_arbiter;

  localparam int ADDR_W  = 14;
  localparam int DATA_W  = 8;
  localparam int FIFO_AW = 4;
  localparam int DEPTH   = 16;
  localparam int MEM_N   = 1 << ADDR_W;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              RD_REQ;
  logic [ADDR_W-1:0] RD_ADDR;
  logic [DATA_W-1:0] RD_DATA;
  logic              RD_VALID;
  logic              WR_REQ;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [DATA_W-1:0] WR_DATA;
  logic              WR_READY;
  logic [ADDR_W-1:0] BRAM_ADDR;
  logic [DATA_W-1:0] BRAM_DIN;
  logic              BRAM_WE;
  logic [DATA_W-1:0] BRAM_DOUT = '0;
  logic [FIFO_AW:0]  FIFO_LEVEL;
  logic              OVERFLOW;

  fb_bram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) dut (
    .CLK(CLK), .RESET(RESET),
    .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
    .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_READY(WR_READY),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_DIN(BRAM_DIN), .BRAM_WE(BRAM_WE), .BRAM_DOUT(BRAM_DOUT),
    .FIFO_LEVEL(FIFO_LEVEL), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // Single-port BRAM with registered output.
  logic [DATA_W-1:0] bram_mem [MEM_N];
  always @(posedge CLK) begin
    BRAM_DOUT <= bram_mem[BRAM_ADDR];
    if (BRAM_WE) bram_mem[BRAM_ADDR] <= BRAM_DIN;
  end

  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_t;
  typedef struct { int due; logic [DATA_W-1:0] data; } rd_t;

  wr_t               q[$];
  rd_t               rdq[$];
  logic [DATA_W-1:0] ref_mem [MEM_N];
  int                cyc = 0;
  logic              exp_we, exp_ovf, exp_valid;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_din, exp_rdata;
  int                n_vec = 0;
  int                n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive(input logic rr, input logic [ADDR_W-1:0] ra,
                       input logic wr, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
    RD_REQ = rr; RD_ADDR = ra; WR_REQ = wr; WR_ADDR = wa; WR_DATA = wd;
  endtask

  // One clock: model the edge from the sampled inputs, then compare at the falling edge.
  task automatic tick();
    logic s_rst, s_rr, s_wr, full;
    logic [ADDR_W-1:0] s_ra, s_wa;
    logic [DATA_W-1:0] s_wd;
    wr_t e;
    rd_t r;
    s_rst = RESET; s_rr = RD_REQ; s_ra = RD_ADDR;
    s_wr = WR_REQ; s_wa = WR_ADDR; s_wd = WR_DATA;
    @(posedge CLK);
    cyc++;
    if (s_rst) begin
      q.delete(); rdq.delete();
      exp_we = 0; exp_addr = '0; exp_din = '0; exp_ovf = 0;
      exp_valid = 0; exp_rdata = '0;
    end else begin
      full = (q.size() == DEPTH);
      exp_valid = 0;
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        r = rdq.pop_front();
        exp_valid = 1;
        exp_rdata = r.data;
      end
      if (s_rr) begin
        r.due = cyc + 2; r.data = ref_mem[s_ra];
        rdq.push_back(r);
        exp_we = 0; exp_addr = s_ra;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        exp_we = 1; exp_addr = e.addr; exp_din = e.data;
        ref_mem[e.addr] = e.data;
      end else begin
        exp_we = 0;
      end
      if (s_wr) begin
        if (full) exp_ovf = 1;
        else begin
          e.addr = s_wa; e.data = s_wd;
          q.push_back(e);
        end
      end
    end
    @(negedge CLK);
    chk("bram_we", BRAM_WE, exp_we);
    chk("bram_addr", BRAM_ADDR, exp_addr);
    chk("bram_din", BRAM_DIN, exp_din);
    chk("fifo_level", FIFO_LEVEL, q.size());
    chk("wr_ready", WR_READY, q.size() != DEPTH);
    chk("overflow", OVERFLOW, exp_ovf);
    chk("rd_valid", RD_VALID, exp_valid);
    chk("rd_data", RD_DATA, exp_rdata);
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    int rd_pct, wr_pct;
    for (int i = 0; i < MEM_N; i++) begin
      v = DATA_W'($urandom);
      bram_mem[i] = v;
      ref_mem[i]  = v;
    end
    bram_mem[14'h0123] = 8'hA5;
    ref_mem[14'h0123]  = 8'hA5;

    // T1: reset with both requests asserted
    RESET = 1;
    drive(1, 14'h0123, 1, 14'h0001, 8'h11);
    tick(); tick();
    RESET = 0;
    drive(0, '0, 0, '0, '0);
    tick();
    chk("t1_wr_ready", WR_READY, 1);

    // T2: single read, data appears after the second following edge
    drive(1, 14'h0123, 0, '0, '0);
    tick();
    drive(0, '0, 0, '0, '0);
    tick();
    chk("t2_not_yet", RD_VALID, 0);
    tick();
    chk("t2_valid", RD_VALID, 1);
    chk("t2_data", RD_DATA, 8'hA5);
    tick();

    // T3: writes queue behind sustained reads, then drain in order
    for (int i = 0; i < 20; i++) begin
      drive(1, ADDR_W'($urandom), i < 5, ADDR_W'(14'h10 + i), DATA_W'(i + 1));
      tick();
    end
    chk("t3_level", FIFO_LEVEL, 5);
    drive(0, '0, 0, '0, '0);
    for (int i = 0; i < 8; i++) tick();
    chk("t3_mem", bram_mem[14'h14], 8'h05);

    // T4: overflow under constant reads, sticky through drain
    for (int i = 0; i < 20; i++) begin
      drive(1, ADDR_W'($urandom), i < 17, ADDR_W'(14'h200 + i), DATA_W'($urandom));
      tick();
    end
    chk("t4_level", FIFO_LEVEL, 16);
    chk("t4_ovf", OVERFLOW, 1);
    drive(0, '0, 0, '0, '0);
    for (int i = 0; i < 20; i++) tick();
    chk("t4_ovf_sticky", OVERFLOW, 1);
    RESET = 1; tick(); RESET = 0; tick();

    // T5: three queued writes interleaved with alternating reads of nearby addresses
    for (int i = 0; i < 3; i++) begin
      drive(1, 14'h40, 1, ADDR_W'(14'h40 + i), DATA_W'($urandom));
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      drive(i % 2 == 0, ADDR_W'(14'h40 + (i % 4)), 0, '0, '0);
      tick();
    end

    // T6: push and pop together keep the level; then many pushes wrap the pointers
    drive(1, 14'h7, 1, 14'h300, 8'h3C);
    tick();
    drive(0, '0, 1, 14'h301, 8'hC3);
    tick();
    chk("t6_level", FIFO_LEVEL, 1);
    for (int i = 0; i < 40; i++) begin
      drive(0, '0, 1, ADDR_W'(14'h300 + i), DATA_W'($urandom));
      tick();
    end
    drive(0, '0, 0, '0, '0);
    for (int i = 0; i < 3; i++) tick();

    // Random traffic with bursty read density and a narrow address window for hazards
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        rd_pct = $urandom_range(0, 100);
        wr_pct = $urandom_range(0, 100);
      end
      RESET = ($urandom_range(0, 499) == 0);
      drive($urandom_range(0, 99) < rd_pct,
            ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 63)) : ADDR_W'($urandom),
            $urandom_range(0, 99) < wr_pct,
            ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 63)) : ADDR_W'($urandom),
            DATA_W'($urandom));
      tick();
    end
    RESET = 0;
    drive(0, '0, 0, '0, '0);
    for (int i = 0; i < 24; i++) tick();
    for (int i = 0; i < 64; i++) chk("final_mem", bram_mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
